dmem_arbiter: RTL and testbench

- Shares the single-port 64-bit data memory between two requesters: the fetch stage (read-only) and the memory stage (read/write, driven by mrmovq/rmmovq/call/ret/pushq/popq).
- Sequences each access through a request/done handshake, checks address bounds, and enforces a backend timeout.
- Reports errors in the same sense as dmem_error.
- Sits between the pipeline stages and the memory array.

---
 rtl/dmem_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two requesters share the single-port 64-bit data memory: the fetch stage
//   (read-only) and the memory stage (read/write). Each access runs as
//   IDLE -> ACCESS -> DONE. An out-of-range address goes straight from IDLE
//   to DONE with an error. A backend that never acks is cut off after
//   TIMEOUT cycles and reported as an error. The memory stage has priority,
//   but fetch is granted after STARVE_MAX back-to-back memory-stage grants.
//   All outputs are registered.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   f_req/f_addr              fetch request, held until f_done
//   f_rdata/f_done/f_err      fetch completion (one-cycle pulse) and data
//   m_req/m_we/m_addr/m_wdata memory-stage request, held until m_done
//   m_rdata/m_done/m_err      memory-stage completion (one-cycle pulse) and data
//   mem_en/mem_we/mem_addr/mem_wdata  backend strobe and command, held until mem_ack
//   mem_rdata/mem_ack         backend read data and one-cycle completion
//   busy                      high whenever the arbiter is not idle
module dmem_arbiter #(
  parameter int MEM_BYTES  = 8192,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic [63:0] f_rdata,
  output logic        f_done,
  output logic        f_err,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic [63:0] m_rdata,
  output logic        m_done,
  output logic        m_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  // Highest legal start address of an 8-byte access. A plain 64-bit
  // compare against this cannot wrap, so addresses near 2^64 stay illegal.
  localparam logic [63:0]      ADDR_MAX = 64'(MEM_BYTES - 8);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT);
  localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

  state_t            state_reg, state_next;
  logic              owner_m_reg, owner_m_next;   // 1 = memory stage owns the access
  logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic [STV_W-1:0]  starve_cnt_reg, starve_cnt_next;

  logic [63:0] f_rdata_reg, f_rdata_next;
  logic        f_done_reg, f_done_next;
  logic        f_err_reg, f_err_next;
  logic [63:0] m_rdata_reg, m_rdata_next;
  logic        m_done_reg, m_done_next;
  logic        m_err_reg, m_err_next;
  logic        mem_en_reg, mem_en_next;
  logic        mem_we_reg, mem_we_next;
  logic [63:0] mem_addr_reg, mem_addr_next;
  logic [63:0] mem_wdata_reg, mem_wdata_next;
  logic        busy_reg, busy_next;

  // Completion request raised by the state logic, routed to the owner below.
  logic        fire;
  logic        fire_err;
  logic [63:0] fire_rdata;
  logic        grant_m, grant_f;
  logic [63:0] req_addr;
  logic [TMO_W-1:0] tmo_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_m_reg    <= 1'b0;
      tmo_cnt_reg    <= '0;
      starve_cnt_reg <= '0;
      f_rdata_reg    <= '0;
      f_done_reg     <= 1'b0;
      f_err_reg      <= 1'b0;
      m_rdata_reg    <= '0;
      m_done_reg     <= 1'b0;
      m_err_reg      <= 1'b0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_m_reg    <= owner_m_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
      f_rdata_reg    <= f_rdata_next;
      f_done_reg     <= f_done_next;
      f_err_reg      <= f_err_next;
      m_rdata_reg    <= m_rdata_next;
      m_done_reg     <= m_done_next;
      m_err_reg      <= m_err_next;
      mem_en_reg     <= mem_en_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_m_next    = owner_m_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    f_rdata_next    = f_rdata_reg;
    f_done_next     = 1'b0;
    f_err_next      = 1'b0;
    m_rdata_next    = m_rdata_reg;
    m_done_next     = 1'b0;
    m_err_next      = 1'b0;
    mem_en_next     = 1'b0;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    fire            = 1'b0;
    fire_err        = 1'b0;
    fire_rdata      = '0;
    grant_m         = 1'b0;
    grant_f         = 1'b0;
    req_addr        = '0;
    tmo_inc         = tmo_cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        grant_m = m_req && !(f_req && (starve_cnt_reg == STV_LIM));
        grant_f = f_req && !grant_m;

        if (!f_req || grant_f) begin
          starve_cnt_next = '0;
        end else if (grant_m && (starve_cnt_reg != STV_LIM)) begin
          starve_cnt_next = starve_cnt_reg + 1'b1;
        end

        if (grant_m || grant_f) begin
          owner_m_next = grant_m;
          req_addr     = grant_m ? m_addr : f_addr;
          if (req_addr <= ADDR_MAX) begin
            state_next     = ACCESS;
            mem_en_next    = 1'b1;
            mem_we_next    = grant_m & m_we;
            mem_addr_next  = req_addr;
            mem_wdata_next = grant_m ? m_wdata : 64'd0;
            tmo_cnt_next   = '0;
          end else begin
            // Range error: report without touching the backend.
            state_next = DONE;
            fire       = 1'b1;
            fire_err   = 1'b1;
          end
        end
      end

      ACCESS: begin
        if (mem_ack) begin
          state_next = DONE;
          fire       = 1'b1;
          fire_rdata = mem_we_reg ? 64'd0 : mem_rdata;
        end else begin
          tmo_cnt_next = tmo_inc;
          if (tmo_inc == TMO_LIM) begin
            state_next = DONE;
            fire       = 1'b1;
            fire_err   = 1'b1;
          end else begin
            mem_en_next = 1'b1;
          end
        end
      end

      DONE: begin
        state_next   = IDLE;
        tmo_cnt_next = '0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (fire) begin
      if (owner_m_next) begin
        m_done_next  = 1'b1;
        m_err_next   = fire_err;
        m_rdata_next = fire_rdata;
      end else begin
        f_done_next  = 1'b1;
        f_err_next   = fire_err;
        f_rdata_next = fire_rdata;
      end
    end

    busy_next = (state_next != IDLE);
  end

  assign f_rdata   = f_rdata_reg;
  assign f_done    = f_done_reg;
  assign f_err     = f_err_reg;
  assign m_rdata   = m_rdata_reg;
  assign m_done    = m_done_reg;
  assign m_err     = m_err_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed requests with hand-computed results.
// Expected completions go into a scoreboard queue; a monitor pops and
// compares whenever a done pulse appears. A backend model acks after a
// programmable delay and checks the command it is handed.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req;
  logic [63:0] f_addr;
  logic [63:0] f_rdata;
  logic        f_done;
  logic        f_err;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_done;
  logic        m_err;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        busy;

  logic bk_ack    = 1'b0;
  logic stray_ack = 1'b0;
  assign mem_ack = bk_ack | stray_ack;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done), .f_err(f_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .m_err(m_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  typedef struct {
    bit          is_m;
    logic [63:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mexp_t;

  exp_t  sb[$];
  mexp_t mq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Backend model controls
  int    ack_delay = 0;
  bit    ack_en    = 1'b1;
  int    acc_cyc   = 0;
  int    en_cnt    = 0;
  mexp_t cur_cmd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one completion at a time, matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (f_done && m_done) begin
        chk("dual_done", {f_done, m_done}, 2'b00);
      end else if (f_done || m_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {f_done, m_done}, 2'b00);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_port", 64'(m_done), 64'(e.is_m));
          chk("done_rdata", m_done ? m_rdata : f_rdata, e.rdata);
          chk("done_err", 64'(m_done ? m_err : f_err), 64'(e.err));
          $display("done port=%s rdata=%h err=%0d", m_done ? "m" : "f",
                   m_done ? m_rdata : f_rdata, m_done ? m_err : f_err);
        end
      end
    end
  end

  // Backend model: checks the command on every strobed cycle, acks after ack_delay.
  always @(negedge clk) begin
    if (mem_en) begin
      if (acc_cyc == 0) begin
        if (mq.size() == 0) begin
          chk("unexpected_mem_en", 64'(mem_en), 64'd0);
          cur_cmd.we = mem_we; cur_cmd.addr = mem_addr; cur_cmd.wdata = mem_wdata;
        end else begin
          cur_cmd = mq.pop_front();
        end
      end
      chk("mem_we", 64'(mem_we), 64'(cur_cmd.we));
      chk("mem_addr", mem_addr, cur_cmd.addr);
      if (cur_cmd.we) chk("mem_wdata", mem_wdata, cur_cmd.wdata);
      en_cnt++;
      bk_ack = (ack_en && acc_cyc == ack_delay);
      acc_cyc++;
    end else begin
      bk_ack  = 1'b0;
      acc_cyc = 0;
    end
  end

  // One request from idle; checks latency from the grant edge when exp_lat > 0.
  task automatic do_req(input bit is_m, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rdata,
                        input bit exp_err, input int exp_lat);
    exp_t  e;
    mexp_t me;
    int    cyc;
    bit    seen;
    @(negedge clk); #1;
    e.is_m = is_m; e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
    if (addr <= 64'h1FF8) begin
      me.we = we; me.addr = addr; me.wdata = wdata;
      mq.push_back(me);
    end
    en_cnt = 0;
    if (is_m) begin
      m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
      seen = is_m ? m_done : f_done;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    else if (exp_lat > 0) chk("latency", 64'(cyc), 64'(exp_lat));
    m_req = 1'b0; f_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int cyc;
    exp_t e;
    mexp_t me;
    bit order_m [10];

    rst = 1'b1;
    f_req = 1'b0; f_addr = '0;
    m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_dones", {62'd0, f_done, m_done}, 64'd0);
    chk("rst_rdata", f_rdata | m_rdata, 64'd0);
    #1 rst = 1'b0;

    // m read, ack in first ACCESS cycle
    mem_rdata = 64'h1234567890ABCDEF; ack_delay = 0;
    do_req(1'b1, 1'b0, 64'h100, 64'd0, 64'h1234567890ABCDEF, 1'b0, 2);
    $display("txn m read 0x100");

    // m write at the top legal address, ack after 3 extra cycles
    ack_delay = 3;
    do_req(1'b1, 1'b1, 64'h1FF8, 64'hABCDEF0123456789, 64'd0, 1'b0, 5);
    chk("write_en_cycles", 64'(en_cnt), 64'd4);
    $display("txn m write 0x1FF8");

    // first illegal address: error in one cycle, no backend access
    do_req(1'b1, 1'b1, 64'h1FF9, 64'h55, 64'd0, 1'b1, 1);
    chk("range_no_mem_en", 64'(en_cnt), 64'd0);
    $display("txn m write 0x1FF9 range error");

    // fetch at the top of the 64-bit space: no wrap in the bound check
    do_req(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1'b1, 1);
    chk("wrap_no_mem_en", 64'(en_cnt), 64'd0);
    $display("txn f read 0xFFFFFFFFFFFFFFF8 range error");

    // stray ack while idle must not start anything
    @(negedge clk); #1 stray_ack = 1'b1;
    @(negedge clk); #1 stray_ack = 1'b0;
    chk("stray_ack_busy", 64'(busy), 64'd0);
    $display("txn stray ack while idle");

    // backend never acks: timeout after 16 strobed cycles
    ack_en = 1'b0; mem_rdata = 64'hDEAD_BEEF_0000_1111;
    do_req(1'b1, 1'b0, 64'h300, 64'd0, 64'd0, 1'b1, 17);
    chk("timeout_en_cycles", 64'(en_cnt), 64'd16);
    @(negedge clk); #1;
    chk("timeout_busy_fall", 64'(busy), 64'd0);
    $display("txn m read 0x300 timeout");
    ack_en = 1'b1; ack_delay = 0;

    // both requesters held: m,m,m,m,f,m,m,m,m,f
    mem_rdata = 64'h0F0F_0F0F_0F0F_0F0F;
    order_m = '{1,1,1,1,0,1,1,1,1,0};
    @(negedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      e.is_m = order_m[i]; e.rdata = 64'h0F0F_0F0F_0F0F_0F0F; e.err = 1'b0;
      sb.push_back(e);
      me.we = 1'b0; me.addr = order_m[i] ? 64'h80 : 64'h40; me.wdata = '0;
      mq.push_back(me);
    end
    f_req = 1'b1; f_addr = 64'h40;
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h80;
    dones = 0; cyc = 0;
    while (dones < 10 && cyc < 300) begin
      @(negedge clk); #1;
      cyc++;
      if (f_done || m_done) dones++;
    end
    f_req = 1'b0; m_req = 1'b0;
    chk("starve_done_count", 64'(dones), 64'd10);
    $display("txn starvation sequence dones=%0d", dones);

    // async reset in the middle of an access
    ack_en = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    me.we = 1'b0; me.addr = 64'h200; me.wdata = '0;
    mq.push_back(me);
    m_req = 1'b1; m_we = 1'b0; m_addr = 64'h200;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_en", 64'(mem_en), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_dones", {62'd0, f_done, m_done}, 64'd0);
    @(negedge clk); #1;
    m_req = 1'b0;
    rst = 1'b0;
    ack_en = 1'b1; ack_delay = 0;
    $display("txn async reset mid-access");
    mem_rdata = 64'h0000_0000_CAFE_F00D;
    do_req(1'b0, 1'b0, 64'h0, 64'd0, 64'h0000_0000_CAFE_F00D, 1'b0, 2);
    $display("txn f read 0x0 after reset");

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("mq_empty", 64'(mq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
